cmem_access_ctrl: RTL and testbench
===================================

Name: cmem_access_ctrl

Overview:
- Sits between the CGRA row controllers, the host/DMA configuration port and the per-row context memories.
- Shares the single address/wdata bus of the context memory between:
  - host kernel-load writes;
  - per-row instruction fetches, which are arbitrated round-robin and broadcast when several rows request the same address.
- Drives the memory clock-enable and retention control through an idle-based power state machine.

Parameters:
- N_ROW, cgra_pkg::N_ROW, number of rows / context memories
- ADDR_W, cgra_pkg::IMEM_N_LINES_LOG2, context memory address width
- DATA_W, 32, instruction/write data width
- IDLE_CYCLES, 64, consecutive idle cycles before entering retention (>=1)
- WAKE_CYCLES, 4, cycles after leaving retention before any grant (>=1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- host_req_i  in  1  host write request
- host_row_sel_i  in  N_ROW  rows to write (multi-hot = broadcast)
- host_addr_i  in  ADDR_W  write address
- host_wdata_i  in  DATA_W  write data
- host_gnt_o  out  1  write accepted this cycle
- row_req_i  in  N_ROW  per-row fetch request
- row_addr_i  in  ADDR_W x N_ROW (unpacked)  per-row fetch address
- row_gnt_o  out  N_ROW  fetch accepted this cycle
- row_rvalid_o  out  N_ROW  read data valid on memory rdata (one cycle after grant)
- cm_row_req_o  out  N_ROW  memory chip select per row
- cm_we_o  out  1  memory write enable
- cm_addr_o  out  ADDR_W  shared memory address
- cm_wdata_o  out  DATA_W  shared write data
- cm_clk_en_o  out  1  clock-gate enable for memories
- cm_set_retentive_no  out  1  low = memories in retention

Behaviour:
- Reset values:
  - all grants, rvalid, cm_row_req_o and cm_we_o = 0;
  - cm_addr_o and cm_wdata_o = 0;
  - cm_clk_en_o = 0;
  - cm_set_retentive_no = 1;
  - FSM = ACTIVE, idle counter = 0, RR pointer = 0, last_was_host = 0.
- Grants and cm_* outputs are combinational from the request inputs and registered state, so a granted access reaches the memory in the same cycle.
- Request/grant rule: a requester holds req and address stable until granted; no retraction is required.
- Arbitration in ACTIVE, per cycle:
  - Host wins if host_req_i && (no row_req || !last_was_host).
  - Otherwise the fetch path wins.
  - Only one side is granted per cycle.
- Host grant:
  - cm_we_o=1, cm_row_req_o=host_row_sel_i, host address and data passed through.
  - If host_row_sel_i==0, the request is granted with no memory access.
- Fetch grant:
  - Winner w = first requesting row at or after the RR pointer, wrapping modulo N_ROW.
  - Every requesting row r with row_addr_i[r]==row_addr_i[w] is also granted (broadcast).
  - cm_addr_o = row_addr_i[w]; cm_row_req_o = the granted set.
  - RR pointer becomes (w+1) mod N_ROW.
- last_was_host is set on a host grant and cleared on a fetch grant.
- row_rvalid_o = row_gnt_o delayed by one cycle (registered). Host writes never produce rvalid.
- cm_clk_en_o = 1 in any cycle with any memory access, and in the cycle after a fetch grant so read data is held valid.
- Power FSM:
  - ACTIVE:
    - The idle counter increments each cycle with no request and clears on any request.
    - When the counter reaches IDLE_CYCLES -> RETENTIVE.
  - RETENTIVE:
    - cm_set_retentive_no=0, cm_clk_en_o=0, no grants.
    - Any request -> WAKEUP.
  - WAKEUP:
    - cm_set_retentive_no=1; a counter loads WAKE_CYCLES-1 and counts down.
    - No grants until the counter reaches 0 -> ACTIVE. Arbitration is allowed in the ACTIVE cycle.
- Boundary conditions:
  - Simultaneous host and fetch requests strictly alternate.
  - An RR pointer at N_ROW-1 wraps to 0.
  - A request arriving in the same cycle the idle counter would saturate keeps the FSM in ACTIVE.
  - An asynchronous reset mid-operation returns all state to reset values immediately. Any in-flight rvalid is dropped.

Optional Feature:
- CMEM_ACCESS_STATS_EN defined:
  - Adds outputs stat_fetch_cnt_o[31:0], stat_bcast_cnt_o[31:0] and stat_stall_cnt_o[31:0], plus input stat_clr_i.
  - stat_fetch_cnt_o counts fetch grant cycles.
  - stat_bcast_cnt_o counts fetch grant cycles that grant more than one row.
  - stat_stall_cnt_o counts cycles in which any row_req_i is asserted but that row is not granted.
  - Counters saturate at 0xFFFFFFFF. stat_clr_i synchronously zeroes all three.
- Macro undefined: the ports and logic are absent.

Decomposition:
- Add to cgra_pkg:
  - cmem_pwr_state_e (CM_ACTIVE, CM_RETENTIVE, CM_WAKEUP);
  - default IDLE_CYCLES and WAKE_CYCLES constants.
- One sub-module, cmem_rr_arbiter: N_ROW-wide round-robin with pointer input and one-hot winner output. Address-match broadcast and the FSM stay in the top.

Test Plan:
- Host writes 0xDEADBEEF to addr 5, rows 0b0101, no fetch -> same-cycle host_gnt_o=1, cm_we_o=1, cm_row_req_o=0b0101, cm_addr_o=5.
- Rows 0..3 all request addr 7 -> single cycle: row_gnt_o=0b1111, cm_addr_o=7; next cycle row_rvalid_o=0b1111.
- Rows 0..3 request distinct addresses 1,2,3,4 held -> grants to rows 0,1,2,3 in successive cycles; pointer wraps and the next grant goes to row 0.
- Host request held plus row 2 request held -> grants alternate host, row2, host, row2; no cycle has both.
- No requests for IDLE_CYCLES=64 cycles -> cm_set_retentive_no=0 in cycle 64. Row 1 requests -> WAKEUP, grant exactly WAKE_CYCLES=4 cycles after the request.
- Reset asserted in the cycle after a fetch grant -> row_rvalid_o=0 immediately; pointer=0, FSM ACTIVE.

Source files
------------

// File: rtl/cgra_pkg.sv
// ---------------------------------------------------------------------------
// cgra_pkg
//   Shared CGRA constants and types. This file holds the array dimensions
//   (row count, context-memory depth) and the context-memory power state
//   encoding with its default idle/wake timing used by cmem_access_ctrl.
// ---------------------------------------------------------------------------
package cgra_pkg;

    // Array geometry
    localparam int N_ROW             = 4;
    localparam int IMEM_N_LINES_LOG2 = 6;

    // Context-memory power management defaults
    localparam int CMEM_IDLE_CYCLES = 64;
    localparam int CMEM_WAKE_CYCLES = 4;

    // Context-memory power state
    typedef enum logic [1:0] {
        CM_ACTIVE    = 2'd0,
        CM_RETENTIVE = 2'd1,
        CM_WAKEUP    = 2'd2
    } cmem_pwr_state_e;

endpackage : cgra_pkg

// File: rtl/cmem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// cmem_access_ctrl_if
//   Shared context-memory bus driven by cmem_access_ctrl towards the per-row
//   context memories.
//
//   Signals:
//     cm_row_req          per-row chip select
//     cm_we               write enable
//     cm_addr             shared address
//     cm_wdata            shared write data
//     cm_clk_en           clock-gate enable for the memories
//     cm_set_retentive_n  low = memories in retention
//
//   Modports:
//     master  access controller side (drives the bus)
//     slave   memory / monitor side (observes the bus)
// ---------------------------------------------------------------------------
interface cmem_access_ctrl_if #(
    parameter int N_ROW  = cgra_pkg::N_ROW,
    parameter int ADDR_W = cgra_pkg::IMEM_N_LINES_LOG2,
    parameter int DATA_W = 32
);

    logic [N_ROW-1:0]  cm_row_req;
    logic              cm_we;
    logic [ADDR_W-1:0] cm_addr;
    logic [DATA_W-1:0] cm_wdata;
    logic              cm_clk_en;
    logic              cm_set_retentive_n;

    modport master (
        output cm_row_req,
        output cm_we,
        output cm_addr,
        output cm_wdata,
        output cm_clk_en,
        output cm_set_retentive_n
    );

    modport slave (
        input cm_row_req,
        input cm_we,
        input cm_addr,
        input cm_wdata,
        input cm_clk_en,
        input cm_set_retentive_n
    );

endinterface : cmem_access_ctrl_if

// File: rtl/cmem_access_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cmem_rr_arbiter
//   Combinational N_ROW-wide round-robin arbiter. Picks the first requester
//   at or after ptr_i, wrapping modulo N_ROW, and returns it one-hot.
//
//   Ports:
//     req_i  in   N_ROW  request vector
//     ptr_i  in   PTR_W  highest-priority index this cycle
//     gnt_o  out  N_ROW  one-hot winner (all zero when no request)
// ---------------------------------------------------------------------------
module cmem_rr_arbiter #(
    parameter int N_ROW = 4,
    parameter int PTR_W = (N_ROW > 1) ? $clog2(N_ROW) : 1
) (
    input  logic [N_ROW-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_ROW-1:0] gnt_o
);

    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N_ROW; i++) begin
            // One extra bit so ptr + i can be folded back below N_ROW even
            // when N_ROW is not a power of two.
            sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N_ROW)) begin
                sum = sum - (PTR_W+1)'(N_ROW);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule : cmem_rr_arbiter

// File: rtl/cmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// cmem_access_ctrl
//   Shares the single address/wdata bus of the per-row context memories
//   between host kernel-load writes and per-row instruction fetches.
//   Fetches are arbitrated round-robin; every requesting row whose address
//   matches the winner's is granted in the same cycle (broadcast). Host and
//   fetch traffic alternate under contention. An idle-based power FSM gates
//   the memory clock and drives retention.
//
//   Grants and cm_* outputs are combinational from the requests and the
//   registered state, so a granted access reaches the memory in the same
//   cycle. row_rvalid_o is the fetch grant delayed by one cycle.
//
//   Ports:
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     host_req_i             host write request
//     host_row_sel_i         rows to write (multi-hot = broadcast)
//     host_addr_i/_wdata_i   write address / data
//     host_gnt_o             write accepted this cycle
//     row_req_i              per-row fetch request
//     row_addr_i             per-row fetch address (unpacked)
//     row_gnt_o              fetch accepted this cycle
//     row_rvalid_o           read data valid on memory rdata
//     cm_row_req_o           memory chip select per row
//     cm_we_o                memory write enable
//     cm_addr_o/cm_wdata_o   shared memory address / write data
//     cm_clk_en_o            memory clock-gate enable
//     cm_set_retentive_no    low = memories in retention
//
//   Optional build macro CMEM_ACCESS_STATS_EN adds stat_clr_i and the
//   saturating counters stat_fetch_cnt_o, stat_bcast_cnt_o and
//   stat_stall_cnt_o.
// ---------------------------------------------------------------------------
module cmem_access_ctrl #(
    parameter int N_ROW       = cgra_pkg::N_ROW,
    parameter int ADDR_W      = cgra_pkg::IMEM_N_LINES_LOG2,
    parameter int DATA_W      = 32,
    parameter int IDLE_CYCLES = cgra_pkg::CMEM_IDLE_CYCLES,
    parameter int WAKE_CYCLES = cgra_pkg::CMEM_WAKE_CYCLES
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              host_req_i,
    input  logic [N_ROW-1:0]  host_row_sel_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,

    input  logic [N_ROW-1:0]  row_req_i,
    input  logic [ADDR_W-1:0] row_addr_i [N_ROW],
    output logic [N_ROW-1:0]  row_gnt_o,
    output logic [N_ROW-1:0]  row_rvalid_o,

`ifdef CMEM_ACCESS_STATS_EN
    input  logic              stat_clr_i,
    output logic [31:0]       stat_fetch_cnt_o,
    output logic [31:0]       stat_bcast_cnt_o,
    output logic [31:0]       stat_stall_cnt_o,
`endif

    output logic [N_ROW-1:0]  cm_row_req_o,
    output logic              cm_we_o,
    output logic [ADDR_W-1:0] cm_addr_o,
    output logic [DATA_W-1:0] cm_wdata_o,
    output logic              cm_clk_en_o,
    output logic              cm_set_retentive_no
);

    import cgra_pkg::*;

    localparam int PTR_W  = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_ROW - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cmem_pwr_state_e   state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              last_was_host_q, last_was_host_d;
    logic [N_ROW-1:0]  rvalid_q;

    // ------------------------------------------------------------------
    // Request summary and arbitration
    // ------------------------------------------------------------------
    logic              any_row_req;
    logic              any_req;
    logic              arb_en;
    logic              retentive_n;
    logic              host_win;
    logic              fetch_win;
    logic [N_ROW-1:0]  win_oh;
    logic [PTR_W-1:0]  win_idx;
    logic [ADDR_W-1:0] win_addr;
    logic [N_ROW-1:0]  row_gnt;
    logic [N_ROW-1:0]  cm_row_req;

    assign any_row_req = |row_req_i;
    assign any_req     = host_req_i | any_row_req;

    // Under contention the host only wins when the previous grant was a
    // fetch, so host and fetch traffic strictly alternate.
    assign host_win  = arb_en & host_req_i & (~any_row_req | ~last_was_host_q);
    assign fetch_win = arb_en & ~host_win & any_row_req;

    cmem_rr_arbiter #(
        .N_ROW (N_ROW),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req_i (row_req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (win_oh)
    );

    always_comb begin
        win_idx = '0;
        for (int r = 0; r < N_ROW; r++) begin
            if (win_oh[r]) begin
                win_idx = PTR_W'(r);
            end
        end
        win_addr = row_addr_i[win_idx];

        // Broadcast: every requester fetching the winner's line rides along.
        row_gnt = '0;
        for (int r = 0; r < N_ROW; r++) begin
            row_gnt[r] = fetch_win & row_req_i[r] & (row_addr_i[r] == win_addr);
        end

        cm_row_req = host_win ? host_row_sel_i : row_gnt;

        rr_ptr_d = rr_ptr_q;
        if (fetch_win) begin
            rr_ptr_d = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
        end

        last_was_host_d = last_was_host_q;
        if (host_win) begin
            last_was_host_d = 1'b1;
        end else if (fetch_win) begin
            last_was_host_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Power FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        wake_cnt_d  = wake_cnt_q;
        arb_en      = 1'b0;
        retentive_n = 1'b1;

        unique case (state_q)
            CM_ACTIVE: begin
                arb_en = 1'b1;
                if (any_req) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    // This idle cycle is the IDLE_CYCLES-th in a row.
                    state_d    = CM_RETENTIVE;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end

            CM_RETENTIVE: begin
                retentive_n = 1'b0;
                if (any_req) begin
                    state_d    = CM_WAKEUP;
                    wake_cnt_d = WAKE_LOAD;
                end
            end

            CM_WAKEUP: begin
                // Leave as the count reaches zero, so the first grant comes
                // WAKE_CYCLES cycles after the waking request.
                if (wake_cnt_q <= WAKE_W'(1)) begin
                    state_d = CM_ACTIVE;
                end
                if (wake_cnt_q != '0) begin
                    wake_cnt_d = wake_cnt_q - WAKE_W'(1);
                end
            end

            default: begin
                state_d = CM_ACTIVE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= CM_ACTIVE;
            idle_cnt_q      <= '0;
            wake_cnt_q      <= '0;
            rr_ptr_q        <= '0;
            last_was_host_q <= 1'b0;
            rvalid_q        <= '0;
        end else begin
            state_q         <= state_d;
            idle_cnt_q      <= idle_cnt_d;
            wake_cnt_q      <= wake_cnt_d;
            rr_ptr_q        <= rr_ptr_d;
            last_was_host_q <= last_was_host_d;
            rvalid_q        <= row_gnt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign host_gnt_o   = host_win;
    assign row_gnt_o    = row_gnt;
    assign row_rvalid_o = rvalid_q;

    assign cm_row_req_o = cm_row_req;
    // A host grant with no rows selected is accepted but touches no memory.
    assign cm_we_o      = host_win & (|host_row_sel_i);
    assign cm_addr_o    = host_win  ? host_addr_i :
                          fetch_win ? win_addr    : '0;
    assign cm_wdata_o   = host_win  ? host_wdata_i : '0;

    // The clock stays on for the cycle after a fetch so rdata remains valid.
    assign cm_clk_en_o         = retentive_n & ((|cm_row_req) | (|rvalid_q));
    assign cm_set_retentive_no = retentive_n;

`ifdef CMEM_ACCESS_STATS_EN
    // ------------------------------------------------------------------
    // Saturating access statistics
    // ------------------------------------------------------------------
    logic [31:0] stat_fetch_q, stat_bcast_q, stat_stall_q;
    logic        bcast_hit;
    logic        stall_hit;

    // More than one bit set: clearing the lowest set bit leaves a residue.
    assign bcast_hit = fetch_win & ((row_gnt & (row_gnt - N_ROW'(1))) != '0);
    assign stall_hit = |(row_req_i & ~row_gnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_fetch_q <= '0;
            stat_bcast_q <= '0;
            stat_stall_q <= '0;
        end else if (stat_clr_i) begin
            stat_fetch_q <= '0;
            stat_bcast_q <= '0;
            stat_stall_q <= '0;
        end else begin
            if (fetch_win && (stat_fetch_q != '1)) stat_fetch_q <= stat_fetch_q + 32'd1;
            if (bcast_hit && (stat_bcast_q != '1)) stat_bcast_q <= stat_bcast_q + 32'd1;
            if (stall_hit && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_fetch_cnt_o = stat_fetch_q;
    assign stat_bcast_cnt_o = stat_bcast_q;
    assign stat_stall_cnt_o = stat_stall_q;
`endif

endmodule : cmem_access_ctrl

// File: tb/tb_cmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cmem_access_ctrl
//   Directed self-checking bench for cmem_access_ctrl. Inputs change on the
//   falling edge; combinational outputs are sampled 1 ns later, registered
//   effects after the following rising edge.
// ---------------------------------------------------------------------------
module tb_cmem_access_ctrl;
    import cgra_pkg::*;

    localparam int NR = cgra_pkg::N_ROW;
    localparam int AW = cgra_pkg::IMEM_N_LINES_LOG2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          host_req;
    logic [NR-1:0] host_row_sel;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [NR-1:0] row_req;
    logic [AW-1:0] row_addr [NR];
    logic [NR-1:0] row_gnt;
    logic [NR-1:0] row_rvalid;
`ifdef CMEM_ACCESS_STATS_EN
    logic          stat_clr;
    logic [31:0]   stat_fetch, stat_bcast, stat_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cmem_access_ctrl_if #(.N_ROW(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    cmem_access_ctrl dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .host_req_i          (host_req),
        .host_row_sel_i      (host_row_sel),
        .host_addr_i         (host_addr),
        .host_wdata_i        (host_wdata),
        .host_gnt_o          (host_gnt),
        .row_req_i           (row_req),
        .row_addr_i          (row_addr),
        .row_gnt_o           (row_gnt),
        .row_rvalid_o        (row_rvalid),
`ifdef CMEM_ACCESS_STATS_EN
        .stat_clr_i          (stat_clr),
        .stat_fetch_cnt_o    (stat_fetch),
        .stat_bcast_cnt_o    (stat_bcast),
        .stat_stall_cnt_o    (stat_stall),
`endif
        .cm_row_req_o        (bus.cm_row_req),
        .cm_we_o             (bus.cm_we),
        .cm_addr_o           (bus.cm_addr),
        .cm_wdata_o          (bus.cm_wdata),
        .cm_clk_en_o         (bus.cm_clk_en),
        .cm_set_retentive_no (bus.cm_set_retentive_n)
    );

    task automatic clear_inputs();
        host_req     = 1'b0;
        host_row_sel = '0;
        host_addr    = '0;
        host_wdata   = '0;
        row_req      = '0;
        for (int i = 0; i < NR; i++) row_addr[i] = '0;
`ifdef CMEM_ACCESS_STATS_EN
        stat_clr     = 1'b0;
`endif
    endtask

    // Leaves the bench on the falling edge where reset was released.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        n_checks++; if (host_gnt !== 1'b0) begin n_errors++; $display("FAIL reset_host_gnt got %0h exp 0", host_gnt); end
        n_checks++; if (row_gnt !== 4'b0000) begin n_errors++; $display("FAIL reset_row_gnt got %0h exp 0", row_gnt); end
        n_checks++; if (row_rvalid !== 4'b0000) begin n_errors++; $display("FAIL reset_rvalid got %0h exp 0", row_rvalid); end
        n_checks++; if (bus.cm_row_req !== 4'b0000) begin n_errors++; $display("FAIL reset_cm_row_req got %0h exp 0", bus.cm_row_req); end
        n_checks++; if (bus.cm_we !== 1'b0) begin n_errors++; $display("FAIL reset_cm_we got %0h exp 0", bus.cm_we); end
        n_checks++; if (bus.cm_addr !== '0) begin n_errors++; $display("FAIL reset_cm_addr got %0h exp 0", bus.cm_addr); end
        n_checks++; if (bus.cm_wdata !== '0) begin n_errors++; $display("FAIL reset_cm_wdata got %0h exp 0", bus.cm_wdata); end
        n_checks++; if (bus.cm_clk_en !== 1'b0) begin n_errors++; $display("FAIL reset_clk_en got %0h exp 0", bus.cm_clk_en); end
        n_checks++; if (bus.cm_set_retentive_n !== 1'b1) begin n_errors++; $display("FAIL reset_ret_n got %0h exp 1", bus.cm_set_retentive_n); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_host_write();
        @(negedge clk);
        host_req = 1'b1; host_row_sel = 4'b0101; host_addr = 6'd5; host_wdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (host_gnt !== 1'b1) begin n_errors++; $display("FAIL host_gnt got %0h exp 1", host_gnt); end
        n_checks++; if (bus.cm_we !== 1'b1) begin n_errors++; $display("FAIL host_we got %0h exp 1", bus.cm_we); end
        n_checks++; if (bus.cm_row_req !== 4'b0101) begin n_errors++; $display("FAIL host_row_req got %0h exp 5", bus.cm_row_req); end
        n_checks++; if (bus.cm_addr !== 6'd5) begin n_errors++; $display("FAIL host_addr got %0h exp 5", bus.cm_addr); end
        n_checks++; if (bus.cm_wdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL host_wdata got %0h exp deadbeef", bus.cm_wdata); end
        n_checks++; if (bus.cm_clk_en !== 1'b1) begin n_errors++; $display("FAIL host_clk_en got %0h exp 1", bus.cm_clk_en); end
        n_checks++; if (row_gnt !== 4'b0000) begin n_errors++; $display("FAIL host_row_gnt got %0h exp 0", row_gnt); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++; if (row_rvalid !== 4'b0000) begin n_errors++; $display("FAIL host_no_rvalid got %0h exp 0", row_rvalid); end
        n_checks++; if (bus.cm_we !== 1'b0) begin n_errors++; $display("FAIL host_we_drop got %0h exp 0", bus.cm_we); end
    endtask

    task automatic test_broadcast();
        apply_reset();
        @(negedge clk);
        row_req = 4'b1111;
        for (int i = 0; i < NR; i++) row_addr[i] = 6'd7;
        #1;
        n_checks++; if (row_gnt !== 4'b1111) begin n_errors++; $display("FAIL bcast_gnt got %0h exp f", row_gnt); end
        n_checks++; if (bus.cm_addr !== 6'd7) begin n_errors++; $display("FAIL bcast_addr got %0h exp 7", bus.cm_addr); end
        n_checks++; if (bus.cm_row_req !== 4'b1111) begin n_errors++; $display("FAIL bcast_row_req got %0h exp f", bus.cm_row_req); end
        n_checks++; if (bus.cm_we !== 1'b0) begin n_errors++; $display("FAIL bcast_we got %0h exp 0", bus.cm_we); end
        @(negedge clk);
        // Pointer is now 1. Row 1 alone on addr 2; rows 0 and 3 share addr 9.
        row_req = 4'b1011;
        row_addr[0] = 6'd9; row_addr[1] = 6'd2; row_addr[3] = 6'd9;
        #1;
        n_checks++; if (row_rvalid !== 4'b1111) begin n_errors++; $display("FAIL bcast_rvalid got %0h exp f", row_rvalid); end
        n_checks++; if (bus.cm_clk_en !== 1'b1) begin n_errors++; $display("FAIL bcast_clk_en got %0h exp 1", bus.cm_clk_en); end
        n_checks++; if (row_gnt !== 4'b0010) begin n_errors++; $display("FAIL pbcast_gnt1 got %0h exp 2", row_gnt); end
        @(negedge clk);
        row_req = 4'b1001;
        #1;
        // Pointer 2: row 3 wins, row 0 joins on the matching address.
        n_checks++; if (row_gnt !== 4'b1001) begin n_errors++; $display("FAIL pbcast_gnt2 got %0h exp 9", row_gnt); end
        n_checks++; if (bus.cm_addr !== 6'd9) begin n_errors++; $display("FAIL pbcast_addr got %0h exp 9", bus.cm_addr); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] pending;
        logic [NR-1:0] exp_gnt;
        apply_reset();
        pending = 4'b1111;
        for (int i = 0; i < NR; i++) row_addr[i] = AW'(i + 1);
        for (int k = 0; k < NR; k++) begin
            @(negedge clk);
            row_req = pending;
            #1;
            exp_gnt = NR'(1) << k;
            n_checks++; if (row_gnt !== exp_gnt) begin n_errors++; $display("FAIL rr_gnt step %0d got %0h exp %0h", k, row_gnt, exp_gnt); end
            n_checks++; if (bus.cm_addr !== AW'(k + 1)) begin n_errors++; $display("FAIL rr_addr step %0d got %0d exp %0d", k, bus.cm_addr, k + 1); end
            if (k > 0) begin
                n_checks++; if (row_rvalid !== (exp_gnt >> 1)) begin n_errors++; $display("FAIL rr_rvalid step %0d got %0h exp %0h", k, row_rvalid, exp_gnt >> 1); end
            end
            pending = pending & ~exp_gnt;
        end
        // Pointer wrapped from row 3 to row 0.
        @(negedge clk);
        row_req = 4'b0101;
        #1;
        n_checks++; if (row_gnt !== 4'b0001) begin n_errors++; $display("FAIL rr_wrap got %0h exp 1", row_gnt); end
        n_checks++; if (row_rvalid !== 4'b1000) begin n_errors++; $display("FAIL rr_wrap_rvalid got %0h exp 8", row_rvalid); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_alternation();
        logic exp_host;
        apply_reset();
        host_row_sel = 4'b0001; host_addr = 6'd3; host_wdata = 32'h0000_1234;
        row_addr[2] = 6'd11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            host_req = 1'b1;
            row_req  = 4'b0100;
            #1;
            exp_host = (k % 2 == 0);
            n_checks++; if (host_gnt !== exp_host) begin n_errors++; $display("FAIL alt_host step %0d got %0h exp %0h", k, host_gnt, exp_host); end
            n_checks++; if (row_gnt !== (exp_host ? 4'b0000 : 4'b0100)) begin n_errors++; $display("FAIL alt_row step %0d got %0h", k, row_gnt); end
            n_checks++; if (bus.cm_addr !== (exp_host ? 6'd3 : 6'd11)) begin n_errors++; $display("FAIL alt_addr step %0d got %0d", k, bus.cm_addr); end
        end
        @(negedge clk);
        clear_inputs();
        // Host request with no rows selected: accepted, no memory access.
        @(negedge clk);
        host_req = 1'b1;
        #1;
        n_checks++; if (host_gnt !== 1'b1) begin n_errors++; $display("FAIL nosel_gnt got %0h exp 1", host_gnt); end
        n_checks++; if (bus.cm_row_req !== 4'b0000) begin n_errors++; $display("FAIL nosel_row_req got %0h exp 0", bus.cm_row_req); end
        n_checks++; if (bus.cm_clk_en !== 1'b0) begin n_errors++; $display("FAIL nosel_clk_en got %0h exp 0", bus.cm_clk_en); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_power_down();
        int wait_cycles;
        apply_reset();
        repeat (63) @(negedge clk);
        #1;
        n_checks++; if (bus.cm_set_retentive_n !== 1'b1) begin n_errors++; $display("FAIL pwr_pre_ret got %0h exp 1", bus.cm_set_retentive_n); end
        @(negedge clk);
        #1;
        n_checks++; if (bus.cm_set_retentive_n !== 1'b0) begin n_errors++; $display("FAIL pwr_ret got %0h exp 0", bus.cm_set_retentive_n); end
        n_checks++; if (bus.cm_clk_en !== 1'b0) begin n_errors++; $display("FAIL pwr_ret_clk_en got %0h exp 0", bus.cm_clk_en); end
        row_req = 4'b0010; row_addr[1] = 6'd5;
        #1;
        n_checks++; if (row_gnt !== 4'b0000) begin n_errors++; $display("FAIL pwr_ret_gnt got %0h exp 0", row_gnt); end
        wait_cycles = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            #1;
            if (k == 1) begin
                n_checks++; if (bus.cm_set_retentive_n !== 1'b1) begin n_errors++; $display("FAIL pwr_wake_ret_n got %0h exp 1", bus.cm_set_retentive_n); end
            end
            if (row_gnt !== 4'b0000 && wait_cycles < 0) wait_cycles = k;
            if (wait_cycles >= 0) break;
        end
        n_checks++; if (wait_cycles != 4) begin n_errors++; $display("FAIL pwr_wake_latency got %0d exp 4", wait_cycles); end
        n_checks++; if (row_gnt !== 4'b0010) begin n_errors++; $display("FAIL pwr_wake_gnt got %0h exp 2", row_gnt); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_idle_boundary();
        apply_reset();
        repeat (63) @(negedge clk);
        // This cycle would complete the idle run; the request must win.
        row_req = 4'b0001; row_addr[0] = 6'd1;
        #1;
        n_checks++; if (row_gnt !== 4'b0001) begin n_errors++; $display("FAIL idle_edge_gnt got %0h exp 1", row_gnt); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++; if (bus.cm_set_retentive_n !== 1'b1) begin n_errors++; $display("FAIL idle_edge_ret_n got %0h exp 1", bus.cm_set_retentive_n); end
        n_checks++; if (row_rvalid !== 4'b0001) begin n_errors++; $display("FAIL idle_edge_rvalid got %0h exp 1", row_rvalid); end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        @(negedge clk);
        row_req = 4'b0001; row_addr[0] = 6'd3;
        #1;
        n_checks++; if (row_gnt !== 4'b0001) begin n_errors++; $display("FAIL midrst_gnt got %0h exp 1", row_gnt); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++; if (row_rvalid !== 4'b0001) begin n_errors++; $display("FAIL midrst_pre_rvalid got %0h exp 1", row_rvalid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (row_rvalid !== 4'b0000) begin n_errors++; $display("FAIL midrst_rvalid got %0h exp 0", row_rvalid); end
        n_checks++; if (bus.cm_clk_en !== 1'b0) begin n_errors++; $display("FAIL midrst_clk_en got %0h exp 0", bus.cm_clk_en); end
        n_checks++; if (bus.cm_set_retentive_n !== 1'b1) begin n_errors++; $display("FAIL midrst_ret_n got %0h exp 1", bus.cm_set_retentive_n); end
        @(negedge clk);
        rst_n = 1'b1;
        // Pointer back at 0: row 0 beats row 1.
        @(negedge clk);
        row_req = 4'b0011; row_addr[0] = 6'd3; row_addr[1] = 6'd4;
        #1;
        n_checks++; if (row_gnt !== 4'b0001) begin n_errors++; $display("FAIL midrst_ptr got %0h exp 1", row_gnt); end
        @(negedge clk);
        clear_inputs();
    endtask

`ifdef CMEM_ACCESS_STATS_EN
    task automatic test_stats();
        apply_reset();
        @(negedge clk);
        row_req = 4'b0011; row_addr[0] = 6'd1; row_addr[1] = 6'd2;
        @(negedge clk);
        row_req = 4'b0010;
        @(negedge clk);
        row_req = 4'b1100; row_addr[2] = 6'd5; row_addr[3] = 6'd5;
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++; if (stat_fetch !== 32'd3) begin n_errors++; $display("FAIL stat_fetch got %0d exp 3", stat_fetch); end
        n_checks++; if (stat_bcast !== 32'd1) begin n_errors++; $display("FAIL stat_bcast got %0d exp 1", stat_bcast); end
        n_checks++; if (stat_stall !== 32'd1) begin n_errors++; $display("FAIL stat_stall got %0d exp 1", stat_stall); end
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #1;
        n_checks++; if (stat_fetch !== 32'd0) begin n_errors++; $display("FAIL stat_clr got %0d exp 0", stat_fetch); end
    endtask
`endif

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_host_write();
        test_broadcast();
        test_round_robin();
        test_alternation();
        test_power_down();
        test_idle_boundary();
        test_reset_midop();
`ifdef CMEM_ACCESS_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cmem_access_ctrl
